// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester sequencer/arbiter sharing one combinational ALU
// Optional feature macro: ALU_ARB_FIXED_PRIO_EN (requester 0 always wins ties).
module alu_arbiter #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0,
  input  logic [2:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [2:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt1,
  output logic [2:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  input  logic             rsp_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Settle counter counts down to zero; one cycle of EXEC is always spent.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       id_r;
  logic       any_req;
  logic       pick1;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic       last_id;
`endif

  // Winner selection and grant pulses; grants exist only while idle.
  always_comb begin
    any_req = req0 | req1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    pick1   = req1 & ~req0;
`else
    pick1   = req1 & (~req0 | ~last_id);
`endif
    gnt0    = (state == IDLE) & any_req & ~pick1;
    gnt1    = (state == IDLE) & pick1;
  end

  // Sequencer: issue to ALU, wait settle interval, capture, hand off response.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      id_r       <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_id    <= 1'b1;
`endif
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            alu_opcode <= pick1 ? op1 : op0;
            alu_a      <= pick1 ? a1 : a0;
            alu_b      <= pick1 ? b1 : b0;
            id_r       <= pick1;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_id    <= pick1;
`endif
            cnt        <= CNT_LOAD;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            rsp_result <= alu_out;
            rsp_flags  <= alu_flags;
            rsp_id     <= id_r;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
